// File: rtl/prga_check.sv
// ARC4 pseudo-random generation stage with printable-ASCII screening.
// Reads a length-prefixed ciphertext from CT memory and XORs it with the
// keystream taken from S, swapping S as it goes. It writes the length-prefixed
// plaintext to PT memory and flags whether every byte is in 0x20..0x7E.
// All outputs are decoded from the state register and internal registers,
// so there is no combinational path from any input to any output.
module prga_check (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic       pt_ok,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE, RD_LEN, WT_LEN, WR_LEN,
        RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ,
        RD_PAD, WT_PAD, WR_PT, DONE
    } state_t;

    state_t     state, state_next;
    logic [7:0] i, j, k, len;
    logic [7:0] si, sj, ctb;
    // Plaintext byte registered at the end of WT_PAD so the PT data output
    // does not depend combinationally on s_rddata.
    logic [7:0] pt_byte;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic for the length phase and the 9-state per-byte loop.
    // NOTE: the default assignment at the top keeps this block latch-free.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = RD_LEN;
            RD_LEN:  state_next = WT_LEN;
            WT_LEN:  state_next = WR_LEN;
            WR_LEN:  state_next = (len == 8'd0) ? DONE : RD_SI;
            RD_SI:   state_next = WT_SI;
            WT_SI:   state_next = RD_SJ;
            RD_SJ:   state_next = WT_SJ;
            WT_SJ:   state_next = WR_SI;
            WR_SI:   state_next = WR_SJ;
            WR_SJ:   state_next = RD_PAD;
            RD_PAD:  state_next = WT_PAD;
            WT_PAD:  state_next = WR_PT;
            WR_PT:   state_next = (k == len) ? DONE : RD_SI;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: indices, captured memory words and the screen flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i       <= 8'd0;
            j       <= 8'd0;
            k       <= 8'd0;
            len     <= 8'd0;
            si      <= 8'd0;
            sj      <= 8'd0;
            ctb     <= 8'd0;
            pt_byte <= 8'd0;
            pt_ok   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    i     <= 8'd0;
                    j     <= 8'd0;
                    k     <= 8'd1;
                    pt_ok <= 1'b1;
                end
                WT_LEN: len <= ct_rddata;
                WR_LEN: i <= 8'd1;
                WT_SI: begin
                    si  <= s_rddata;
                    ctb <= ct_rddata;
                    j   <= j + s_rddata;
                end
                WT_SJ:  sj <= s_rddata;
                WT_PAD: pt_byte <= s_rddata ^ ctb;
                WR_PT: begin
                    if (pt_byte < 8'h20 || pt_byte > 8'h7E) pt_ok <= 1'b0;
                    if (k != len) begin
                        k <= k + 8'd1;
                        i <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-port decode; WT states hold their RD address so the RAM output
    // stays stable through the capture edge.
    always_comb begin
        rdy       = (state == IDLE);
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state)
            WR_LEN: begin
                pt_wrdata = len;
                pt_wren   = 1'b1;
            end
            RD_SI, WT_SI: begin
                s_addr  = i;
                ct_addr = k;
            end
            RD_SJ, WT_SJ: s_addr = j;
            WR_SI: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
            end
            WR_SJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
            end
            RD_PAD, WT_PAD: s_addr = si + sj;
            WR_PT: begin
                pt_addr   = k;
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prga_check.sv
// Self-checking bench for prga_check: behavioural synchronous RAMs for S, CT
// and PT, directed vectors with hand-computed results, and an ARC4 model for
// the long key-schedule run.
module tb_prga_check;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy, pt_ok;
    logic [7:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
    logic [7:0] s_rddata, ct_rddata;
    logic       s_wren, pt_wren;

    prga_check dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .pt_ok(pt_ok),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;
    logic       ld_s_we = 1'b0;
    logic       ld_ct_we = 1'b0;
    int         s_wr_cnt = 0;
    int         pt_wr_cnt = 0;

    // Synchronous single-port RAMs; the bench loads S and CT through a side port.
    always @(posedge clk) begin
        if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
            s_wr_cnt      <= s_wr_cnt + 1;
        end else if (ld_s_we) begin
            s_mem[ld_addr] <= ld_data;
        end
        s_rddata <= s_mem[s_addr];
    end

    always @(posedge clk) begin
        if (ld_ct_we) ct_mem[ld_addr] <= ld_data;
        ct_rddata <= ct_mem[ct_addr];
    end

    always @(posedge clk) begin
        if (pt_wren) begin
            pt_mem[pt_addr] <= pt_wrdata;
            pt_wr_cnt       <= pt_wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic ld(input bit to_s, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_addr  = a;
        ld_data  = d;
        ld_s_we  = to_s;
        ld_ct_we = !to_s;
    endtask

    task automatic ld_end();
        @(negedge clk);
        ld_s_we  = 1'b0;
        ld_ct_we = 1'b0;
    endtask

    task automatic load_s_identity();
        for (int n = 0; n < 256; n++) ld(1'b1, n[7:0], n[7:0]);
        ld_end();
    endtask

    // Pulse en, then count busy cycles until rdy returns (bounded).
    task automatic run(input bit noise, output int cyc);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        cyc = 0;
        while (!rdy && cyc < 3000) begin
            en = noise && (cyc % 40 == 7);
            @(posedge clk);
            #1 en = 1'b0;
            cyc++;
        end
    endtask

    logic [7:0] m_s [256];
    logic [7:0] m_ct [256];
    logic [7:0] m_pt [256];
    logic       m_ok;

    initial begin
        int         cyc;
        int         s_snap, pt_snap, errs;
        logic [7:0] key [3];
        logic [7:0] mi, mj, tmp, sum;

        // Reset state.
        #1;
        check("rst_rdy", rdy, 1);
        check("rst_pt_ok", pt_ok, 0);
        check("rst_s_wren", s_wren, 0);
        check("rst_pt_wren", pt_wren, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_pt_addr", pt_addr, 0);
        #20 rst_n = 1'b1;

        // L=1, 'A' -> pad S[2]=2 -> 0x43.
        load_s_identity();
        ld(1'b0, 8'd0, 8'd1); ld(1'b0, 8'd1, 8'h41); ld_end();
        run(1'b0, cyc);
        check("l1_cycles", cyc, 13);
        check("l1_pt0", pt_mem[0], 8'd1);
        check("l1_pt1", pt_mem[1], 8'h43);
        check("l1_s1", s_mem[1], 8'd1);
        check("l1_ok", pt_ok, 1);

        // L=2 -> 0x43, 0x40 and S[2]/S[3] swapped.
        load_s_identity();
        ld(1'b0, 8'd0, 8'd2); ld(1'b0, 8'd1, 8'h41); ld(1'b0, 8'd2, 8'h45); ld_end();
        run(1'b0, cyc);
        check("l2_cycles", cyc, 22);
        check("l2_pt0", pt_mem[0], 8'd2);
        check("l2_pt1", pt_mem[1], 8'h43);
        check("l2_pt2", pt_mem[2], 8'h40);
        check("l2_s2", s_mem[2], 8'd3);
        check("l2_s3", s_mem[3], 8'd2);
        check("l2_ok", pt_ok, 1);

        // Non-printable byte clears pt_ok.
        load_s_identity();
        ld(1'b0, 8'd0, 8'd1); ld(1'b0, 8'd1, 8'h02); ld_end();
        run(1'b0, cyc);
        check("np_pt1", pt_mem[1], 8'h00);
        check("np_ok", pt_ok, 0);

        // A printable run afterwards sets it again.
        load_s_identity();
        ld(1'b0, 8'd1, 8'h41); ld_end();
        run(1'b0, cyc);
        check("rp_pt1", pt_mem[1], 8'h43);
        check("rp_ok", pt_ok, 1);

        // Empty message: one PT write, no S writes.
        ld(1'b0, 8'd0, 8'd0); ld_end();
        s_snap  = s_wr_cnt;
        pt_snap = pt_wr_cnt;
        run(1'b0, cyc);
        check("l0_cycles", cyc, 4);
        check("l0_s_writes", s_wr_cnt - s_snap, 0);
        check("l0_pt_writes", pt_wr_cnt - pt_snap, 1);
        check("l0_pt0", pt_mem[0], 8'd0);
        check("l0_ok", pt_ok, 1);

        // Key 0x000018 key schedule, 255-byte message, en noise during the run.
        key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
        for (int n = 0; n < 256; n++) m_s[n] = n[7:0];
        mj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            mj = mj + m_s[n] + key[n % 3];
            tmp = m_s[n]; m_s[n] = m_s[mj]; m_s[mj] = tmp;
        end
        for (int n = 0; n < 256; n++) ld(1'b1, n[7:0], m_s[n]);
        m_ct[0] = 8'd255;
        for (int n = 1; n < 256; n++) m_ct[n] = 8'(n * 13 + 8'h55);
        for (int n = 0; n < 256; n++) ld(1'b0, n[7:0], m_ct[n]);
        ld_end();
        mi = 8'd0; mj = 8'd0; m_ok = 1'b1; m_pt[0] = 8'd255;
        for (int n = 1; n < 256; n++) begin
            mi  = mi + 8'd1;
            mj  = mj + m_s[mi];
            tmp = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = tmp;
            sum = m_s[mi] + m_s[mj];
            m_pt[n] = m_ct[n] ^ m_s[sum];
            if (m_pt[n] < 8'h20 || m_pt[n] > 8'h7E) m_ok = 1'b0;
        end
        run(1'b1, cyc);
        check("l255_cycles", cyc, 2299);
        check("l255_pt0", pt_mem[0], 8'd255);
        check("l255_pt1", pt_mem[1], m_pt[1]);
        check("l255_pt255", pt_mem[255], m_pt[255]);
        errs = 0;
        for (int n = 0; n < 256; n++) if (pt_mem[n] !== m_pt[n]) errs++;
        check("l255_pt_mismatches", errs, 0);
        errs = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) errs++;
        check("l255_s_mismatches", errs, 0);
        check("l255_ok", pt_ok, m_ok);
        check("l255_rdy_after_noise", rdy, 1);

        // Asynchronous reset at the 30th busy cycle of a 20-byte run.
        load_s_identity();
        ld(1'b0, 8'd0, 8'd20);
        for (int n = 1; n <= 20; n++) ld(1'b0, n[7:0], 8'h41);
        ld_end();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (29) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_rdy", rdy, 1);
        check("ar_s_wren", s_wren, 0);
        check("ar_pt_wren", pt_wren, 0);
        check("ar_pt_ok", pt_ok, 0);
        s_snap  = s_wr_cnt;
        pt_snap = pt_wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("ar_no_s_writes", s_wr_cnt - s_snap, 0);
        check("ar_no_pt_writes", pt_wr_cnt - pt_snap, 0);
        @(negedge clk) rst_n = 1'b1;

        // Clean restart after reset.
        load_s_identity();
        ld(1'b0, 8'd0, 8'd2); ld(1'b0, 8'd1, 8'h41); ld(1'b0, 8'd2, 8'h45); ld_end();
        run(1'b0, cyc);
        check("pr_cycles", cyc, 22);
        check("pr_pt0", pt_mem[0], 8'd2);
        check("pr_pt1", pt_mem[1], 8'h43);
        check("pr_pt2", pt_mem[2], 8'h40);
        check("pr_ok", pt_ok, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
